// File: rtl/gf163_reduce_pkg.sv
// Shared constants, types and helpers for the GF(2^163) reduction pipeline.
// The field polynomial is f(x) = x^163 + x^7 + x^6 + x^3 + 1.
// The squaring option is enabled by the GF163_REDUCE_SQR_EN macro. That macro
// only affects gf163_reduce; this package always provides spread().
package gf163_pkg;

  // Field degree and the width of an unreduced product (2M-1).
  localparam int unsigned M = 163;
  localparam int unsigned N = 2 * M - 1;

  // Low-order terms of f(x): x^163 == x^7 + x^6 + x^3 + 1.
  localparam int unsigned NTAPS   = 4;
  localparam int unsigned TAPS [NTAPS] = '{7, 6, 3, 0};
  localparam int unsigned TAP_MAX = 7;

  // Stage 1 folds the 162-bit high half, so the partial result reaches degree 168.
  localparam int unsigned H1W = N - M;          // 162
  localparam int unsigned R1W = H1W + TAP_MAX;  // 169

  // Stage 2 folds what sits above x^162 in the stage-1 register.
  localparam int unsigned H2W = R1W - M;        // 6

  typedef logic [M-1:0]   gf_elem_t;
  typedef logic [N-1:0]   gf_prod_t;
  typedef logic [R1W-1:0] gf_part_t;

  // Squaring in GF(2^m) has no cross terms: coefficient i of a moves to bit 2i.
  function automatic gf_prod_t spread(input gf_elem_t a);
    gf_prod_t p;
    p = '0;
    for (int i = 0; i < int'(M); i++) begin
      p[2*i] = a[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/gf163_reduce_fold.sv
// gf163_fold: one combinational reduction step. It XORs a high part into a
// low part once for each tap of f(x), with the high part shifted by that tap.
// HW is the high-part width. OW is the result width and must be at least
// max(M, HW + TAP_MAX) for the caller to keep every term.
module gf163_fold
  import gf163_pkg::*;
#(
  parameter int unsigned HW = H1W,
  parameter int unsigned OW = R1W
) (
  input  logic [M-1:0]  i_lo,
  input  logic [HW-1:0] i_hi,
  output logic [OW-1:0] o_res
);

  // Accumulate lo ^ (hi << t) over every tap t.
  always_comb begin
    // NOTE: o_res is assigned in full before the loop, so every path writes it
    // and no latch can be inferred.
    o_res = OW'(i_lo);
    for (int t = 0; t < int'(NTAPS); t++) begin
      o_res = o_res ^ (OW'(i_hi) << TAPS[t]);
    end
  end

endmodule

// File: rtl/gf163_reduce.sv
// gf163_reduce: two-stage valid/ready pipeline that reduces a 325-bit
// carry-less product modulo x^163 + x^7 + x^6 + x^3 + 1.
//   Stage 1 folds bits [324:163] into a 169-bit partial result.
//   Stage 2 folds bits [168:163] of that partial result into the final
//   163-bit element.
// Both stages stall independently. A stage can drain and refill on the same
// edge, so the pipeline accepts one product per cycle.
// Optional feature: define GF163_REDUCE_SQR_EN to add the `sqr` input. When
// sqr is 1, stage 1 squares in_data[162:0] instead of using the full product.
module gf163_reduce
  import gf163_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
`ifdef GF163_REDUCE_SQR_EN
  input  logic         sqr,
`endif
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         busy
);

  // Pipeline state
  logic     r_s1_v;
  logic     r_s2_v;
  gf_part_t r_r1;
  gf_elem_t r_out_data;

  // Combinational nets
  gf_prod_t w_prod;
  gf_part_t w_r1_next;
  gf_elem_t w_out_next;
  logic     w_s1_load;
  logic     w_s2_load;

  // Choose the stage-1 operand: the multiplier's product, or the square of the low half.
`ifdef GF163_REDUCE_SQR_EN
  assign w_prod = sqr ? spread(in_data[M-1:0]) : in_data;
`else
  assign w_prod = in_data;
`endif

  // Fold 1: the 162-bit high half goes into the low 163 bits. The result reaches degree 168.
  gf163_fold #(
    .HW (H1W),
    .OW (R1W)
  ) u_fold1 (
    .i_lo  (w_prod[M-1:0]),
    .i_hi  (w_prod[N-1:M]),
    .o_res (w_r1_next)
  );

  // Fold 2: the 6 bits above x^162 produce terms of degree 12 or less, so no third fold is needed.
  gf163_fold #(
    .HW (H2W),
    .OW (M)
  ) u_fold2 (
    .i_lo  (r_r1[M-1:0]),
    .i_hi  (r_r1[R1W-1:M]),
    .o_res (w_out_next)
  );

  // Handshake.
  // Stage 2 takes stage 1's data when it is empty or is being drained this cycle.
  // Stage 1 can accept when it is empty or can pass its data forward.
  assign w_s2_load = r_s1_v && (!r_s2_v || out_ready);
  assign in_ready  = !r_s1_v || !r_s2_v || out_ready;
  assign w_s1_load = in_valid && in_ready;

  // Update the valid flags and stage data. Synchronous reset overrides any
  // accept in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are cleared as well as the valid flags,
      // because out_data must read 0 after reset.
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_r1       <= '0;
      r_out_data <= '0;
    end else begin
      // NOTE: non-blocking assignments here. The update of r_s1_v and the
      // load of r_s2_v both read the pre-edge state.
      if (w_s1_load) begin
        r_s1_v <= 1'b1;
        r_r1   <= w_r1_next;
      end else if (w_s2_load) begin
        r_s1_v <= 1'b0;
      end

      if (w_s2_load) begin
        r_s2_v     <= 1'b1;
        r_out_data <= w_out_next;
      end else if (out_ready) begin
        r_s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_data  = r_out_data;
  assign busy      = r_s1_v | r_s2_v;

endmodule
